// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: state encoding,
// default widths and the duty-bus lane helper.
package pwm_pkg;

  localparam int CNT_W_DEF = 14;
  localparam int NCH_DEF   = 4;
  localparam int DT_W_DEF  = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

  // LSB position of lane 'lane' in a flat bus of 'w'-bit lanes.
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time shaper for one channel: p/n rise only after raw has held its level
// for 'deadtime' clks, and both fall one clk after the raw edge; no backpressure.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            raw,
  input  logic [DT_W-1:0] deadtime,
  output logic            p,
  output logic            n
);

  logic            raw_q, raw_d;
  logic            p_q, p_d;
  logic            n_q, n_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic [DT_W-1:0] held;
  logic            same;

  // cnt_q is how many clks raw has sat at raw_q so far; it saturates so a
  // long steady level always satisfies any deadtime value.
  always_comb begin
    same  = (raw == raw_q);
    held  = same ? cnt_q : '0;
    raw_d = raw;
    if (!same) begin
      cnt_d = DT_W'(1);
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + DT_W'(1);
    end
    p_d = raw && (held >= deadtime);
    n_d = !raw && (held >= deadtime);
    if (clr) begin
      raw_d = 1'b0;
      cnt_d = '0;
      p_d   = 1'b0;
      n_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q <= 1'b0;
      cnt_q <= '0;
      p_q   <= 1'b0;
      n_q   <= 1'b0;
    end else begin
      raw_q <= raw_d;
      cnt_q <= cnt_d;
      p_q   <= p_d;
      n_q   <= n_d;
    end
  end

  assign p = p_q;
  assign n = n_q;

endmodule

// File: rtl/pwm_multichannel_gen.sv
// Multi-channel PWM: shared period counter, NCH comparators, period/duty committed at period boundaries.
// Outputs lag the counter by 1 clk; no backpressure. PWM_DEADTIME_EN adds complementary dead-time pairs.
module pwm_multichannel_gen
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int DT_W  = DT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [CNT_W-1:0]     period,
  input  logic [NCH*CNT_W-1:0] duty,
  input  logic                 load,
  input  logic [DT_W-1:0]      deadtime,
  output logic [NCH-1:0]       pwm_out,
  output logic [NCH-1:0]       pwm_n,
  output logic                 period_end,
  output logic                 upd_pend
);

  pwm_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          per_act_q, per_act_d;
  logic [CNT_W-1:0]          per_sh_q, per_sh_d;
  logic [NCH-1:0][CNT_W-1:0] duty_act_q, duty_act_d;
  logic [NCH-1:0][CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic                      upd_pend_q, upd_pend_d;
  logic                      period_end_q, period_end_d;
  logic                      run, live, wrap, commit;
  logic [NCH-1:0]            raw;

  always_comb begin
    state_d    = enable ? ST_RUN : ST_IDLE;
    run        = (state_q == ST_RUN);
    live       = run && enable;
    wrap       = run && (cnt_q == per_act_q);
    // IDLE has no waveform to protect, so a pending update lands at once.
    commit     = upd_pend_q && (!run || wrap);
    per_act_d  = per_act_q;
    duty_act_d = duty_act_q;
    per_sh_d   = per_sh_q;
    duty_sh_d  = duty_sh_q;
    upd_pend_d = upd_pend_q;
    if (commit) begin
      per_act_d  = per_sh_q;
      duty_act_d = duty_sh_q;
      upd_pend_d = 1'b0;
    end
    if (load) begin
      per_sh_d = period;
      for (int i = 0; i < NCH; i++) begin
        duty_sh_d[i] = duty[lane_lsb(i, CNT_W) +: CNT_W];
      end
      upd_pend_d = 1'b1;
    end
    cnt_d        = (state_d == ST_RUN && run && !wrap) ? cnt_q + CNT_W'(1) : '0;
    period_end_d = (state_d == ST_RUN) && (cnt_d == per_act_d);
    raw          = '0;
    for (int i = 0; i < NCH; i++) begin
      raw[i] = live && (cnt_q < duty_act_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      per_act_q    <= '0;
      per_sh_q     <= '0;
      duty_act_q   <= '0;
      duty_sh_q    <= '0;
      upd_pend_q   <= 1'b0;
      period_end_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      per_act_q    <= per_act_d;
      per_sh_q     <= per_sh_d;
      duty_act_q   <= duty_act_d;
      duty_sh_q    <= duty_sh_d;
      upd_pend_q   <= upd_pend_d;
      period_end_q <= period_end_d;
    end
  end

  assign period_end = period_end_q;
  assign upd_pend   = upd_pend_q;

`ifdef PWM_DEADTIME_EN
  for (genvar i = 0; i < NCH; i++) begin : g_dt
    pwm_deadtime #(
      .DT_W(DT_W)
    ) u_dt (
      .clk     (clk),
      .rst     (rst),
      .clr     (!live),
      .raw     (raw[i]),
      .deadtime(deadtime),
      .p       (pwm_out[i]),
      .n       (pwm_n[i])
    );
  end
`else
  logic [NCH-1:0] pwm_q, pwm_d;
  logic           unused_deadtime;

  always_comb begin
    pwm_d = raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out         = pwm_q;
  assign pwm_n           = '0;
  assign unused_deadtime = ^deadtime;
`endif

endmodule

// File: tb/tb_pwm_multichannel_gen.sv
// Scoreboard bench for pwm_multichannel_gen: reference model predicts each clk's outputs,
// a monitor pops and compares one entry per clk.
module tb_pwm_multichannel_gen;

  localparam int CNT_W  = 14;
  localparam int NCH    = 4;
  localparam int DT_W   = 6;
  localparam int DT_MAX = (1 << DT_W) - 1;

  typedef struct packed {
    logic [NCH-1:0] pwm;
    logic [NCH-1:0] pwn;
    logic           pe;
    logic           up;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst, enable, load;
  logic [CNT_W-1:0]     period;
  logic [NCH*CNT_W-1:0] duty;
  logic [DT_W-1:0]      deadtime;
  logic [NCH-1:0]       pwm_out, pwm_n;
  logic                 period_end, upd_pend;

  always #5 clk = ~clk;

  pwm_multichannel_gen #(
    .CNT_W(CNT_W),
    .NCH  (NCH),
    .DT_W (DT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .period    (period),
    .duty      (duty),
    .load      (load),
    .deadtime  (deadtime),
    .pwm_out   (pwm_out),
    .pwm_n     (pwm_n),
    .period_end(period_end),
    .upd_pend  (upd_pend)
  );

  // Reference model: where we are inside the current period, the live and
  // staged settings, and for dead-time how long each channel has held its level.
  bit    m_run;
  int    m_pos, m_per, s_per;
  bit    m_pend;
  int    m_duty[NCH];
  int    s_duty[NCH];
  bit    lvl[NCH];
  int    len[NCH];

  exp_t  sbq[$];
  string tagq[$];
  string phase;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic model_step(output exp_t e);
    bit [NCH-1:0] want_hi;
    bit           live, at_bound;
    int           held;
    e = '0;
    if (rst) begin
      m_run = 0; m_pos = 0; m_per = 0; s_per = 0; m_pend = 0;
      for (int i = 0; i < NCH; i++) begin
        m_duty[i] = 0; s_duty[i] = 0; lvl[i] = 0; len[i] = 0;
      end
    end else begin
      live = m_run && enable;
      for (int i = 0; i < NCH; i++) want_hi[i] = live && (m_pos < m_duty[i]);
      // The last position of a period (or any idle clk) is where staged settings take over.
      at_bound = !m_run || (m_pos == m_per);
      if (m_pend && at_bound) begin
        m_per = s_per;
        for (int i = 0; i < NCH; i++) m_duty[i] = s_duty[i];
        m_pend = 0;
      end
      if (load) begin
        s_per = int'(period);
        for (int i = 0; i < NCH; i++) s_duty[i] = int'(duty[i*CNT_W +: CNT_W]);
        m_pend = 1;
      end
      m_pos = (!enable || at_bound) ? 0 : m_pos + 1;
      m_run = enable;
      e.pe  = enable && (m_pos == m_per);
      e.up  = m_pend;
`ifdef PWM_DEADTIME_EN
      for (int i = 0; i < NCH; i++) begin
        if (!live) begin
          lvl[i] = 0; len[i] = 0;
        end else begin
          held = (want_hi[i] == lvl[i]) ? len[i] : 0;
          e.pwm[i] = want_hi[i] && (held >= int'(deadtime));
          e.pwn[i] = !want_hi[i] && (held >= int'(deadtime));
          len[i] = (want_hi[i] == lvl[i]) ? ((len[i] < DT_MAX) ? len[i] + 1 : DT_MAX) : 1;
          lvl[i] = want_hi[i];
        end
      end
`else
      e.pwm = want_hi;
`endif
    end
  endtask

  task automatic cyc();
    exp_t e;
    model_step(e);
    sbq.push_back(e);
    tagq.push_back(phase);
    @(negedge clk);
  endtask

  task automatic do_load(input int per, input int d0, input int d1, input int d2, input int d3);
    period = CNT_W'(per);
    duty[0*CNT_W +: CNT_W] = CNT_W'(d0);
    duty[1*CNT_W +: CNT_W] = CNT_W'(d1);
    duty[2*CNT_W +: CNT_W] = CNT_W'(d2);
    duty[3*CNT_W +: CNT_W] = CNT_W'(d3);
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  // Advance until the next sampling edge sees counter position p (p<0: last count of period).
  task automatic wait_pos(input int p);
    int k;
    for (k = 0; k < 100; k++) begin
      if (m_run && ((p < 0) ? (m_pos == m_per) : (m_pos == p))) break;
      cyc();
    end
    if (k == 100) begin
      $display("FAIL wait_pos(%0d): position never reached, model at %0d", p, m_pos);
      miscompares++;
    end
  endtask

  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        t = tagq.pop_front();
        vectors++;
        if ({pwm_out, pwm_n, period_end, upd_pend} !== e) begin
          miscompares++;
          $display("FAIL %s @%0t: got pwm_out=%b pwm_n=%b period_end=%b upd_pend=%b, expected %b %b %b %b",
                   t, $time, pwm_out, pwm_n, period_end, upd_pend, e.pwm, e.pwn, e.pe, e.up);
        end
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1; enable = 1'b0; load = 1'b0; period = '0; duty = '0; deadtime = '0;
    phase = "reset";
    repeat (3) cyc();
    rst = 1'b0;
    phase = "idle";
    repeat (2) cyc();

    phase = "basic_duty";
    do_load(9, 3, 0, 10, 5);
    enable = 1'b1;
    repeat (35) cyc();

    phase = "reload_mid_period";
    wait_pos(2);
    do_load(4, 2, 0, 5, 4);
    repeat (25) cyc();

    phase = "load_in_commit_cycle";
    do_load(7, 1, 7, 8, 3);
    wait_pos(-1);
    do_load(6, 2, 2, 2, 2);
    repeat (30) cyc();

    phase = "reset_mid_period";
    do_load(9, 3, 0, 10, 5);
    repeat (20) cyc();
    wait_pos(1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    enable = 1'b0;
    repeat (3) cyc();

    phase = "period_zero";
    do_load(0, 1, 0, 1, 3);
    enable = 1'b1;
    repeat (10) cyc();

    phase = "enable_toggle";
    do_load(5, 2, 6, 0, 3);
    repeat (8) cyc();
    enable = 1'b0;
    repeat (3) cyc();
    enable = 1'b1;
    repeat (12) cyc();

`ifdef PWM_DEADTIME_EN
    phase = "deadtime";
    deadtime = DT_W'(2);
    do_load(19, 10, 10, 3, 1);
    repeat (70) cyc();
    deadtime = DT_W'(0);
    repeat (30) cyc();
    phase = "deadtime_period_zero";
    do_load(0, 1, 1, 1, 1);
    repeat (10) cyc();
`endif

    phase = "random";
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 11) == 0) begin
        load   = 1'b1;
        period = CNT_W'($urandom_range(0, 12));
        for (int i = 0; i < NCH; i++) duty[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 14));
        deadtime = DT_W'($urandom_range(0, 3));
      end else begin
        load = 1'b0;
      end
      cyc();
    end
    rst = 1'b0;
    load = 1'b0;

    for (k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
    if (sbq.size() > 0) begin
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sbq.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
